// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU over 32 cycles,
// plus MTHI/MTLO. Ports: clock, reset, start, op, operand_a/b -> busy, done, div_by_zero, hi/lo_out.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t state, state_n;

  // mul: acc = {partial product, remaining multiplier}
  // div: acc[WIDTH-1:0] = dividend shifting out, quotient shifting in
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   rem;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic               neg_r;
  logic               is_div;
  logic               zero_div;

  logic               sgn;
  logic               is_mul_op;
  logic               is_div_op;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               last;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   remv;

  assign sgn       = ~op[0];
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign mag_a     = (sgn && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign mag_b     = (sgn && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  assign last      = (cnt == CW'(WIDTH - 1));

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, mcand} : '0);

  assign shifted = {rem, acc[WIDTH-1]};
  assign trial   = shifted - {1'b0, mcand};

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remv = neg_r ? -rem : rem;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start && is_mul_op)      state_n = S_MUL;
        else if (start && is_div_op) state_n = S_DIV;
      end
      S_MUL:   if (last) state_n = S_FIX;
      S_DIV:   if (last) state_n = S_FIX;
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc         <= '0;
      mcand       <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      is_div      <= 1'b0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MTHI) hi_out <= operand_a;
            if (op == OP_MTLO) lo_out <= operand_a;
            if (is_mul_op) begin
              acc         <= {{WIDTH{1'b0}}, mag_b};
              mcand       <= mag_a;
              neg_q       <= sgn & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
              neg_r       <= 1'b0;
              is_div      <= 1'b0;
              zero_div    <= 1'b0;
              cnt         <= '0;
            end
            if (is_div_op) begin
              acc         <= {{WIDTH{1'b0}}, mag_a};
              mcand       <= mag_b;
              rem         <= '0;
              neg_q       <= sgn & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
              neg_r       <= sgn & operand_a[WIDTH-1];
              is_div      <= 1'b1;
              zero_div    <= (operand_b == '0);
              cnt         <= '0;
            end
            // Sticky flag lives until the next real operation
            if (is_mul_op || is_div_op || op == OP_MTHI || op == OP_MTLO)
              div_by_zero <= 1'b0;
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        S_DIV: begin
          // Restore when the trial subtraction goes negative
          if (trial[WIDTH]) rem <= shifted[WIDTH-1:0];
          else              rem <= trial[WIDTH-1:0];
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          done        <= 1'b1;
          div_by_zero <= is_div & zero_div;
          if (!is_div) begin
            hi_out <= prod[2*WIDTH-1:WIDTH];
            lo_out <= prod[WIDTH-1:0];
          end else if (!zero_div) begin
            hi_out <= remv;
            lo_out <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit for the MIPS datapath. It sits directly downstream of the 32x32 register file: its operands are the two register read ports (rs, rt), and its HI/LO outputs feed the MFHI/MFLO writeback mux. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO with a start/busy/done handshake, so the pipeline stalls on busy.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- start  in  1  request; accepted only when busy=0.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 ignored (no effect).
- operand_a  in  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source).
- operand_b  in  WIDTH  rt value (multiplier / divisor).
- busy  out  1  high while a MULT/DIV operation is in flight.
- done  out  1  one-cycle pulse when HI/LO have been updated by a MULT/DIV.
- div_by_zero  out  1  valid with done; 1 if the completed DIV/DIVU had a zero divisor.
- hi_out  out  WIDTH  architectural HI register.
- lo_out  out  WIDTH  architectural LO register.

## Operation
- States: IDLE, MUL, DIV, FIX. Reset in any state forces IDLE; hi_out=0, lo_out=0, busy=0, done=0, div_by_zero=0, iteration counter=0.
- IDLE, start=1, op=4/5: HI (or LO) <= operand_a at that edge; stay IDLE; busy and done stay 0.
- IDLE, start=1, op=0/1: latch |a|, |b| (op=0 signed two's-complement magnitude, op=1 raw) and result sign = a[31]^b[31] (op=0 only); go to MUL.
- IDLE, start=1, op=2/3: latch magnitudes, quotient sign = a[31]^b[31], remainder sign = a[31] (op=2 only); set internal dbz = (b==0); go to DIV.
- MUL: shift-add, one multiplier bit per cycle, into a 64-bit internal accumulator; after 32 iterations go to FIX.
- DIV: restoring division, one quotient bit per cycle; 33-bit partial remainder; after 32 iterations go to FIX.
- FIX: apply sign correction (negate the 64-bit product; negate quotient and/or remainder independently). Write HI/LO, pulse done, go to IDLE.
- MULT/MULTU: HI:LO = full 64-bit product.
- DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no flag.
- Divide by zero: HI/LO are not written; div_by_zero=1 for the done cycle. Latency is unchanged.
- div_by_zero is cleared on the next accepted start and on reset.
- start while busy=1 is ignored; no queueing. Operands are sampled only at the accepting edge, so later changes on operand_a/b have no effect.
- HI/LO hold their previous values for the whole operation. No partial results are ever visible.
- op 6/7 with start: no state change.

## Timing
- Edge E0: start accepted. busy=1 from E0+1.
- Iterations occupy E1..E32. FIX executes at E33: HI/LO are written, done=1, busy=0 for the cycle after E33.
- Total: busy is high for exactly 33 cycles. done pulses for exactly 1 cycle, coincident with the first cycle of busy=0.
- A new start may be accepted on the same cycle that done is high (back-to-back issue).
- MTHI/MTLO: 1-cycle latency, visible on hi_out/lo_out the cycle after the accepting edge.
- Reset asserted mid-operation aborts the operation with no done pulse. Outputs take their reset values after that edge.

## Test plan
- MULT a=7, b=0xFFFFFFFD (-3) → after 33 busy cycles, done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then MULT with the same operands → HI=0, LO=1.
- DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands → LO=0x7FFFFFFC, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload MTHI 0x1234, MTLO 0x5678, then DIV 5/0 → done after 33 cycles, div_by_zero=1, HI=0x1234, LO=0x5678. Next accepted start clears the flag.
- Start MULT 3*4. Reassert start (DIV 9/3) at cycle 10 → ignored; final HI=0, LO=12. Then issue DIV 9/3 on the done cycle → accepted; LO=3, HI=0.
- Reset at cycle 15 of MULT 100*100 → busy=0, done stays 0, HI=LO=0. A following MULT 2*3 gives LO=6.
